uart_tx_frame: RTL and testbench

- Self-timed UART transmitter: integrated oversampling baud-tick generator plus frame FSM.
- Serialises a data_wd-bit word as: start bit, data LSB-first, optional parity bit, stop bit.
- Sits between a host parallel interface (din/tx_start) and the serial tx pad.
- Reports busy and one-cycle done status.

---
 rtl/uart_tx_frame_pkg.sv | 22 ++
 rtl/uart_tick_gen.sv | 33 +++
 rtl/uart_tx_frame.sv | 122 ++++++++++++
 tb/tb_uart_tx_frame.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_frame_pkg.sv
// rtl/uart_tx_frame_pkg.sv - shared FSM states, parity codes and baud divisor helper
package uart_tx_frame_pkg;

   // One-hot frame states
   typedef enum logic [5:0] {
      IDLE   = 6'b000001,
      START  = 6'b000010,
      DATA   = 6'b000100,
      PARITY = 6'b001000,
      STOP   = 6'b010000,
      DONE   = 6'b100000
   } state_t;

   localparam logic [1:0] PAR_ODD  = 2'd1;
   localparam logic [1:0] PAR_EVEN = 2'd2;

   // Clocks per oversampling tick, truncated
   function automatic int calc_div(input int clk_freq, input int baud, input int osr);
      return clk_freq / (baud * osr);
   endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// rtl/uart_tick_gen.sv - free-running oversampling baud tick divider
module uart_tick_gen
   import uart_tx_frame_pkg::*;
#(
   parameter int BAUD              = 9600,
   parameter int clk_freq          = 50_000_000,
   parameter int oversampling_rate = 16
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int DIV = calc_div(clk_freq, BAUD, oversampling_rate);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // Count 0..DIV-1 and wrap; runs continuously from reset release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - self-timed UART transmitter with start/data/parity/stop framing
module uart_tx_frame
   import uart_tx_frame_pkg::*;
#(
   parameter int         BAUD              = 9600,
   parameter int         clk_freq          = 50_000_000,
   parameter int         oversampling_rate = 16,
   parameter int         data_wd           = 8,
   parameter logic [1:0] parity            = 2'd1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tx_start,
   input  logic [data_wd-1:0] din,
   output logic               tx,
   output logic               tx_done,
   output logic               tx_busy
);

   localparam int TCW = (oversampling_rate > 1) ? $clog2(oversampling_rate) : 1;
   localparam int BW  = (data_wd > 1) ? $clog2(data_wd) : 1;
   localparam logic [TCW-1:0] TICK_LAST = TCW'(oversampling_rate - 1);
   localparam logic [BW-1:0]  BIT_LAST  = BW'(data_wd - 1);
   localparam bit PAR_EN = (parity == PAR_ODD) || (parity == PAR_EVEN);

   state_t             state, state_n;
   logic [TCW-1:0]     tick_count, tick_count_n;
   logic [BW-1:0]      bit_index, bit_index_n;
   logic [data_wd-1:0] data_q, data_n;
   logic               parity_res, parity_n;
   logic               tick;
   logic               bit_end;

   uart_tick_gen #(
      .BAUD              (BAUD),
      .clk_freq          (clk_freq),
      .oversampling_rate (oversampling_rate)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Last tick of the current serial bit
   assign bit_end = tick && (tick_count == TICK_LAST);

   // State, counters and latched word
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         tick_count <= '0;
         bit_index  <= '0;
         data_q     <= '0;
         parity_res <= 1'b0;
      end else begin
         state      <= state_n;
         tick_count <= tick_count_n;
         bit_index  <= bit_index_n;
         data_q     <= data_n;
         parity_res <= parity_n;
      end
   end

   // Next state, counter updates and Moore line outputs
   always_comb begin
      state_n      = state;
      tick_count_n = tick_count;
      bit_index_n  = bit_index;
      data_n       = data_q;
      parity_n     = parity_res;
      tx           = 1'b1;
      tx_done      = 1'b0;
      tx_busy      = 1'b0;
      case (state)
         IDLE: begin
            if (tx_start) begin
               data_n       = din;
               parity_n     = (parity == PAR_EVEN) ? ^din : ~^din;
               tick_count_n = '0;
               bit_index_n  = '0;
               state_n      = START;
            end
         end
         START: begin
            tx      = 1'b0;
            tx_busy = 1'b1;
            if (bit_end) state_n = DATA;
         end
         DATA: begin
            tx      = data_q[bit_index];
            tx_busy = 1'b1;
            if (bit_end) begin
               if (bit_index == BIT_LAST) begin
                  bit_index_n = '0;
                  state_n     = PAR_EN ? PARITY : STOP;
               end else begin
                  bit_index_n = bit_index + 1'b1;
               end
            end
         end
         PARITY: begin
            tx      = parity_res;
            tx_busy = 1'b1;
            if (bit_end) state_n = STOP;
         end
         STOP: begin
            tx_busy = 1'b1;
            if (bit_end) state_n = DONE;
         end
         DONE: begin
            tx_done = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // Oversampling counter only runs while a bit is on the line
      if (tx_busy && tick) begin
         tick_count_n = bit_end ? '0 : tick_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed self-checking bench for uart_tx_frame
module tb_uart_tx_frame;

   localparam int TB_BAUD = 5;
   localparam int TB_CLK  = 250;
   localparam int TB_OSR  = 16;
   localparam int TB_DIV  = 3;

   localparam logic [5:0] ST_IDLE  = 6'b000001;
   localparam logic [5:0] ST_START = 6'b000010;
   localparam logic [5:0] ST_DONE  = 6'b100000;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_start, tx_start_np;
   logic [7:0] din, din_np;
   logic       tx, tx_done, tx_busy;
   logic       tx_np, tx_done_np, tx_busy_np;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   uart_tx_frame #(
      .BAUD(TB_BAUD), .clk_freq(TB_CLK), .oversampling_rate(TB_OSR),
      .data_wd(8), .parity(2'd1)
   ) dut (
      .clk(clk), .rst(rst), .tx_start(tx_start), .din(din),
      .tx(tx), .tx_done(tx_done), .tx_busy(tx_busy)
   );

   uart_tx_frame #(
      .BAUD(TB_BAUD), .clk_freq(TB_CLK), .oversampling_rate(TB_OSR),
      .data_wd(8), .parity(2'd0)
   ) dut_np (
      .clk(clk), .rst(rst), .tx_start(tx_start_np), .din(din_np),
      .tx(tx_np), .tx_done(tx_done_np), .tx_busy(tx_busy_np)
   );

   task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic tick_of(input bit sel);
      return sel ? dut_np.tick : dut.tick;
   endfunction

   function automatic logic [5:0] state_of(input bit sel);
      return sel ? dut_np.state : dut.state;
   endfunction

   function automatic logic [2:0] line_of(input bit sel);
      return sel ? {tx_np, tx_done_np, tx_busy_np} : {tx, tx_done, tx_busy};
   endfunction

   // Return #1 after the n-th tick edge
   task automatic wait_ticks(input int n, input bit sel);
      int cnt = 0;
      int cyc = 0;
      while (cnt < n && cyc <= n * TB_DIV + 10) begin
         @(negedge clk);
         cyc++;
         if (tick_of(sel)) cnt++;
      end
      if (cnt < n) check(32'(cnt), 32'(n), "tick timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [7:0] d, input bit sel);
      @(negedge clk);
      if (sel) begin din_np = d; tx_start_np = 1'b1; end
      else     begin din = d;    tx_start = 1'b1;    end
      @(posedge clk);
      #1;
      check(32'(state_of(sel)), 32'(ST_START), "enter start");
      if (sel) begin din_np = ~d; tx_start_np = 1'b0; end
      else     begin din = ~d;    tx_start = 1'b0;    end
   endtask

   // Called #1 after START entry; returns #1 after DONE->IDLE edge
   task automatic check_frame(input logic [7:0] d, input bit sel, input string tag);
      int   nb;
      logic e;
      logic [2:0] ln;
      nb = sel ? 10 : 11;
      for (int b = 0; b < nb; b++) begin
         if (b == 0)                e = 1'b0;
         else if (b <= 8)           e = d[b-1];
         else if (b == 9 && !sel)   e = ~^d;
         else                       e = 1'b1;
         wait_ticks(12, sel);
         ln = line_of(sel);
         check(32'(ln[2]), 32'(e), $sformatf("%s bit%0d tx", tag, b));
         check(32'(ln[1:0]), 32'b01, $sformatf("%s bit%0d done/busy", tag, b));
         wait_ticks(4, sel);
      end
      check(32'(line_of(sel)), 32'b110, $sformatf("%s done pulse", tag));
      check(32'(state_of(sel)), 32'(ST_DONE), $sformatf("%s done state", tag));
      @(posedge clk);
      #1;
      check(32'(line_of(sel)), 32'b100, $sformatf("%s after done", tag));
      check(32'(state_of(sel)), 32'(ST_IDLE), $sformatf("%s idle", tag));
   endtask

   initial begin
      logic [7:0] rnd [5];
      int gap;
      rst = 1'b0; tx_start = 1'b0; tx_start_np = 1'b0; din = '0; din_np = '0;

      // reset
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check(32'({tx, tx_done, tx_busy}), 32'b100, "reset outputs");
      check(32'(dut.state), 32'(ST_IDLE), "reset state");
      check(32'(dut.tick_count), 32'd0, "reset tick_count");
      check(32'(dut.bit_index), 32'd0, "reset bit_index");
      check(32'(tx_np), 32'd1, "reset np tx");

      // tick spacing: 250/(5*16) truncates to 3
      wait_ticks(1, 1'b0);
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (!dut.tick && gap < 20);
      check(32'(gap), 32'd3, "tick spacing");

      // single frame 0xD3
      start_frame(8'hD3, 1'b0);
      check_frame(8'hD3, 1'b0, "d3");

      // five back-to-back frames, tx_start held throughout
      for (int k = 0; k < 5; k++) rnd[k] = 8'($urandom);
      @(negedge clk);
      din = rnd[0];
      tx_start = 1'b1;
      @(posedge clk);
      #1;
      check(32'(dut.state), 32'(ST_START), "b2b enter0");
      din = ~rnd[0];
      check_frame(rnd[0], 1'b0, "b2b0");
      for (int k = 1; k < 5; k++) begin
         din = rnd[k];
         @(posedge clk);
         #1;
         check(32'(dut.state), 32'(ST_START), $sformatf("b2b enter%0d", k));
         din = ~rnd[k];
         check_frame(rnd[k], 1'b0, $sformatf("b2b%0d", k));
      end
      tx_start = 1'b0;
      @(posedge clk);
      #1;
      check(32'(dut.state), 32'(ST_IDLE), "b2b stays idle");

      // reset mid-frame after four data bits
      start_frame(8'hD3, 1'b0);
      wait_ticks(16 + 16 * 4 + 6, 1'b0);
      check(32'(dut.bit_index), 32'd4, "mid bit_index");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check(32'({tx, tx_done, tx_busy}), 32'b100, "midrst outputs");
      check(32'(dut.state), 32'(ST_IDLE), "midrst state");
      check(32'({dut.tick_count, 4'(dut.bit_index)}), 32'd0, "midrst counters");
      check(32'(dut.data_q), 32'd0, "midrst data");
      @(negedge clk);
      rst = 1'b1;

      // corner words
      start_frame(8'hFF, 1'b0);
      check_frame(8'hFF, 1'b0, "ff");
      start_frame(8'h00, 1'b0);
      check_frame(8'h00, 1'b0, "00");

      // no-parity build: 10 bits, stop follows bit 7 directly
      start_frame(8'hD3, 1'b1);
      check_frame(8'hD3, 1'b1, "np");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
